// File: rtl/lock_input_conditioner.sv
// Synchronizes and debounces the lock's raw buttons and slide switches into the Clk domain.
// Key pulse / Password change lands DEBOUNCE_CYCLES+2 edges after a stable raw change; no backpressure.
module lock_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       KeyRaw1,
  input  logic       KeyRaw2,
  input  logic [3:0] PasswordRaw,
  output logic       Key1,
  output logic       Key2,
  output logic [3:0] Password
);

  localparam int NCH = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel order: bit 0 = button 1, bit 1 = button 2, bits 5:2 = switches.
  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1;
  logic [NCH-1:0] s2;
  logic [NCH-1:0] db;
  logic [1:0]     rise;

  assign raw = {PasswordRaw, KeyRaw2, KeyRaw1};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic             db_q;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             expire;

    assign differ = s2[i] ^ db_q;
    assign expire = differ && (cnt == CNT_MAX);

    // Any cycle where s2 matches db restarts the count, so short bounces never land.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        db_q <= 1'b0;
        cnt  <= '0;
      end else begin
        if (expire) begin
          db_q <= s2[i];
        end
        if (differ && !expire) begin
          cnt <= cnt + CNT_W'(1);
        end else begin
          cnt <= '0;
        end
      end
    end

    assign db[i] = db_q;

    if (i < 2) begin : g_key
      assign rise[i] = expire & s2[i];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Key1 <= 1'b0;
      Key2 <= 1'b0;
    end else begin
      Key1 <= rise[0];
      Key2 <= rise[1];
    end
  end

  assign Password = db[5:2];

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Directed bench for lock_input_conditioner with DEBOUNCE_CYCLES = 4; a windowed
// reference model is compared every cycle alongside hand-computed edge expectations.
module tb_lock_input_conditioner;

  localparam int D = 4;

  logic       Clk;
  logic       Reset;
  logic       KeyRaw1;
  logic       KeyRaw2;
  logic [3:0] PasswordRaw;
  logic       Key1;
  logic       Key2;
  logic [3:0] Password;

  int vectors;
  int miscompares;

  lock_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .KeyRaw1     (KeyRaw1),
    .KeyRaw2     (KeyRaw2),
    .PasswordRaw (PasswordRaw),
    .Key1        (Key1),
    .Key2        (Key2),
    .Password    (Password)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: s2 is raw delayed by two edges; db toggles once the last D
  // synchronized samples all disagree with it. A key pulses when its db toggles to 1.
  logic [5:0] m_s1, m_s2, m_db;
  logic [5:0] hist [D];
  logic       m_k1, m_k2;
  bit         m_ok;

  initial m_ok = 1'b0;

  always @(posedge Clk) begin
    if (Reset) begin
      m_s1 = '0;
      m_s2 = '0;
      m_db = '0;
      m_k1 = 1'b0;
      m_k2 = 1'b0;
      for (int j = 0; j < D; j++) hist[j] = '0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      logic [5:0] rise_m;
      rise_m = '0;
      for (int ch = 0; ch < 6; ch++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int j = 0; j < D; j++)
          if (hist[j][ch] == m_db[ch]) all_diff = 1'b0;
        if (all_diff) begin
          m_db[ch]   = ~m_db[ch];
          rise_m[ch] = m_db[ch];
        end
      end
      m_k1 = rise_m[0];
      m_k2 = rise_m[1];
      m_s2 = m_s1;
      m_s1 = {PasswordRaw, KeyRaw2, KeyRaw1};
      for (int j = D - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = m_s2;
    end
  end

  always @(negedge Clk) begin
    if (m_ok) begin
      chk1("model_key1", Key1, m_k1);
      chk1("model_key2", Key2, m_k2);
      chk4("model_password", Password, m_db[5:2]);
    end
  end

  task automatic cyc();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    logic bounce [6];
    vectors     = 0;
    miscompares = 0;
    bounce      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // 1: reset, then hold button 1
    Reset = 1'b1; KeyRaw1 = 1'b0; KeyRaw2 = 1'b0; PasswordRaw = 4'b0000;
    cyc();
    cyc();
    chk1("reset_key1", Key1, 1'b0);
    chk1("reset_key2", Key2, 1'b0);
    chk4("reset_password", Password, 4'b0000);
    Reset = 1'b0;
    KeyRaw1 = 1'b1;
    for (int e = 1; e <= 56; e++) begin
      cyc();
      chk1("hold_key1", Key1, e == 6);
      chk1("hold_key2", Key2, 1'b0);
    end
    KeyRaw1 = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      cyc();
      chk1("release_no_pulse", Key1, 1'b0);
    end

    // 2: bounce on button 2, then steady press
    for (int e = 1; e <= 30; e++) begin
      KeyRaw2 = (e <= 6) ? bounce[e-1] : 1'b1;
      cyc();
      chk1("bounce_key2", Key2, e == 11);
      chk1("bounce_key1", Key1, 1'b0);
    end

    // 3: password settles, then a short excursion is filtered
    PasswordRaw = 4'b1101;
    for (int e = 1; e <= 12; e++) begin
      cyc();
      chk4("pw_settle", Password, (e >= 6) ? 4'b1101 : 4'b0000);
    end
    for (int e = 1; e <= 16; e++) begin
      PasswordRaw = (e <= 2) ? 4'b0111 : 4'b1101;
      cyc();
      chk4("pw_glitch", Password, 4'b1101);
    end

    // 4: simultaneous presses, minimum release gap, second pair
    KeyRaw1 = 1'b0;
    KeyRaw2 = 1'b0;
    repeat (12) cyc();
    for (int e = 1; e <= 25; e++) begin
      KeyRaw1 = (e <= 6) || (e >= 12);
      KeyRaw2 = (e <= 6) || (e >= 12);
      cyc();
      chk1("pair_key1", Key1, (e == 6) || (e == 17));
      chk1("pair_key2", Key2, (e == 6) || (e == 17));
    end
    KeyRaw1 = 1'b0;
    KeyRaw2 = 1'b0;
    repeat (12) cyc();

    // 5: reset one edge before the pulse would land
    for (int e = 1; e <= 20; e++) begin
      KeyRaw1 = 1'b1;
      Reset   = (e == 5);
      cyc();
      chk1("rst_key1", Key1, e == 11);
      if (e == 5) begin
        chk1("rst_edge_key2", Key2, 1'b0);
        chk4("rst_edge_password", Password, 4'b0000);
      end
      if (e >= 5)
        chk4("rst_password", Password, (e >= 11) ? 4'b1101 : 4'b0000);
    end
    Reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
